// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int CALC_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, bout is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first through one cell.
// Optional SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow output.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is accepted
// SHIFT | one bit per cycle through the cell, WIDTH cycles
// DONE  | one-cycle done pulse; diff/borrow_out hold the new result
module serial_subtractor
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow),
    .d   (cell_d),
    .bout(cell_bout)
  );

  assign res_next = {cell_d, res_sr[WIDTH-1:1]};
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= cell_bout;
          cnt    <= cnt + CW'(1);
          // Final bit: publish the whole word at once so partial results never show.
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= res_next;
            borrow_out <= cell_bout;
            state      <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] vec_a[8] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h10, 8'h7F, 8'hA5};
  logic [W-1:0] vec_b[8] = '{8'h03, 8'h05, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h80, 8'hA5};

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] full;
    full     = {1'b0, x} - {1'b0, y};
    e.diff   = full[W-1:0];
    e.borrow = full[W];
    e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start from IDLE and record its expected result.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit timed_out);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, required all 0",
               busy, done, diff, borrow_out);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b, required 0", overflow);
    end
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_latency();
    exp_t e;
    launch(8'h05, 8'h03);
    for (int i = 1; i <= W; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h00) begin
        errors++;
        $display("FAIL basic_shift_cycle%0d: busy=%b done=%b diff=%h, required busy=1 done=0 diff=00",
                 i, busy, done, diff);
      end
      tick();
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== e.diff || borrow_out !== e.borrow) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b diff=%h borrow=%b, required done=1 busy=0 diff=%h borrow=%b",
               done, busy, diff, borrow_out, e.diff, e.borrow);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== e.diff) begin
      errors++;
      $display("FAIL basic_after_done: done=%b busy=%b diff=%h, required done=0 busy=0 diff=%h",
               done, busy, diff, e.diff);
    end
  endtask

  task automatic test_vectors();
    exp_t e;
    int   n;
    bit   to;
    for (int v = 0; v < 8; v++) begin
      launch(vec_a[v], vec_b[v]);
      wait_done(n, to);
      checks++;
      if (to || n != W) begin
        errors++;
        $display("FAIL vec%0d_latency: done after %0d cycles (timeout=%0b), required %0d",
                 v, n, to, W);
      end
      e = sb.pop_front();
      checks++;
      if (diff !== e.diff || borrow_out !== e.borrow) begin
        errors++;
        $display("FAIL vec%0d_result a=%h b=%h: diff=%h borrow=%b, required diff=%h borrow=%b",
                 v, vec_a[v], vec_b[v], diff, borrow_out, e.diff, e.borrow);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (overflow !== e.ovf) begin
        errors++;
        $display("FAIL vec%0d_overflow a=%h b=%h: got %b, required %b",
                 v, vec_a[v], vec_b[v], overflow, e.ovf);
      end
`endif
      tick();
      tick();
    end
  endtask

  task automatic test_start_ignored();
    exp_t         e;
    int           ndone = 0;
    int           done_at = -1;
    logic [W-1:0] got_diff = '0;
    logic         got_borrow = 1'b0;
    launch(8'h5A, 8'h33);
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        a = 8'h01; b = 8'hF0; start = 1'b1;
      end else if (i == 9) begin
        a = 8'hC3; b = 8'h11; start = 1'b1;
      end
      if (done) begin
        ndone++;
        done_at    = i;
        got_diff   = diff;
        got_borrow = borrow_out;
      end
      tick();
      start = 1'b0;
    end
    e = sb.pop_front();
    checks++;
    if (ndone != 1 || done_at != W + 1) begin
      errors++;
      $display("FAIL ignore_done_count: %0d pulses at cycle %0d, required 1 at cycle %0d",
               ndone, done_at, W + 1);
    end
    checks++;
    if (got_diff !== e.diff || got_borrow !== e.borrow) begin
      errors++;
      $display("FAIL ignore_result: diff=%h borrow=%b, required diff=%h borrow=%b",
               got_diff, got_borrow, e.diff, e.borrow);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   ndone = 0;
    int   n;
    bit   to;
    launch(8'h77, 8'h12);
    sb.delete();
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b diff=%h borrow=%b, required all 0",
               busy, done, diff, borrow_out);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL async_reset_no_done: %0d done pulses, required 0", ndone);
    end
    launch(8'h40, 8'h41);
    wait_done(n, to);
    e = sb.pop_front();
    checks++;
    if (to || n != W || diff !== e.diff || borrow_out !== e.borrow) begin
      errors++;
      $display("FAIL after_reset_op: cycles=%0d diff=%h borrow=%b, required cycles=%0d diff=%h borrow=%b",
               n, diff, borrow_out, W, e.diff, e.borrow);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ba[5] = '{8'h20, 8'h01, 8'h99, 8'hF0, 8'h00};
    logic [W-1:0] bb[5] = '{8'h10, 8'h02, 8'h33, 8'h0F, 8'h00};
    exp_t         e;
    int           pushed = 0;
    int           ndone = 0;
    logic [W-1:0] last_diff;
    last_diff = diff;
    a     = ba[0];
    b     = bb[0];
    start = 1'b1;
    tick();
    sb.push_back(model(ba[0], bb[0]));
    pushed = 1;
    a = ba[1];
    b = bb[1];
    for (int t = 1; t <= 4 * (W + 2); t++) begin
      tick();
      if (done) begin
        ndone++;
        checks++;
        if (sb.size() == 0 || t % (W + 2) != W) begin
          errors++;
          $display("FAIL b2b_done_timing: done at cycle %0d, required cycle %% %0d == %0d",
                   t, W + 2, W);
        end else begin
          e = sb.pop_front();
          checks++;
          if (diff !== e.diff || borrow_out !== e.borrow) begin
            errors++;
            $display("FAIL b2b_result%0d: diff=%h borrow=%b, required diff=%h borrow=%b",
                     ndone, diff, borrow_out, e.diff, e.borrow);
          end
        end
        last_diff = diff;
      end else if (diff !== last_diff) begin
        checks++;
        errors++;
        $display("FAIL b2b_diff_hold: diff=%h at cycle %0d, required %h", diff, t, last_diff);
      end
      if (t % (W + 2) == 0 && pushed < 4) begin
        sb.push_back(model(ba[pushed], bb[pushed]));
        pushed++;
        a = ba[pushed];
        b = bb[pushed];
        if (pushed == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: %0d done pulses, %0d pending, required 4 and 0",
               ndone, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_vectors();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor for the calculator datapath. Computes diff = a - b one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow.
- Inverse operation to the adder chain, traded for area: one cell instead of WIDTH cascaded cells.
- Controlled by a start/busy/done handshake from the calculator control FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge where start is accepted.
- b  input  WIDTH  subtrahend; sampled with a.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; diff/borrow_out valid.
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff unsigned a < b.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift regs, bit counter and borrow cleared. Reset mid-operation aborts with no done pulse.
- States and transitions:
  - IDLE: start=1 latches a and b into shift regs, clears borrow and counter, and moves to SHIFT.
  - SHIFT: per cycle, operand bits x=a_sr[0], y=b_sr[0] and borrow bin give d=x^y^bin, bout=(~x&y)|(~(x^y)&bin). d shifts into result MSB; a_sr and b_sr shift right; the counter increments. After WIDTH SHIFT cycles, move to DONE.
  - DONE: lasts exactly one cycle, then IDLE.
- busy=1 exactly while in SHIFT. done=1 exactly while in DONE.
- Output update: diff and borrow_out load from the result shift reg and the final borrow on the SHIFT->DONE edge. They then hold until the next DONE; intermediate shift contents are never visible on diff.
- Latency: start accepted at edge k; done high in the cycle following edge k+WIDTH (WIDTH+1 cycles from start sample). Throughput is one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored and not queued. a and b may change freely after acceptance.
- Counter width is clog2(WIDTH+1). No wrap before the WIDTH-th bit.
- Boundaries:
  - a==b gives diff=0, borrow_out=0.
  - a=0, b=all-ones gives diff=1, borrow_out=1.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), registered alongside diff. overflow = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), which is signed two's-complement overflow; the operand MSBs are captured at start. overflow resets to 0 and holds like diff.
- Undefined: port and capture logic are absent; all other behaviour is identical.

Decomposition:
- Package calc_pkg:
  - state enum type sub_state_t {IDLE, SHIFT, DONE}, 2-bit encoding.
  - constant CALC_WIDTH_DEFAULT = 8.
- Sub-module full_subtractor: purely combinational 1-bit cell with ports x, y, bin, d, bout. It is instantiated once inside serial_subtractor.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, start at edge 0 -> busy high for 8 cycles; done at cycle 9; diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. a=0x00, b=0xFF -> diff=0x01, borrow_out=1. a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- With SERIAL_SUB_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. a=0x10, b=0x01 -> overflow=0.
- start pulsed with new operands at cycles 3 and 9 of a running op -> both ignored; result matches the original operands; exactly one done pulse.
- rst asserted asynchronously at cycle 4 of an op -> busy, done, diff and borrow_out drop to 0 immediately; no done pulse; a subsequent start completes correctly.
- Back-to-back: start held high continuously -> new op accepted each time IDLE is reached; period WIDTH+2=10 cycles; diff changes only on done cycles.
